execute: RTL and testbench
==========================

Name: execute

Overview:
- Execute stage of the 64-bit in-order pipeline. Sits between the decode/execute pipeline register and the memory stage.
- Computes `aluout` for ALU ops and load/store addresses, and passes the store data and control through to the memory stage.
- Single-cycle ALU ops are combinational.
- MUL/DIV/REM ops run on an internal iterative unit and hold the pipeline through `stallexe` until the result is ready.

Parameters:
- XLEN, 64, datapath width.
- ITER, 64, iterations of the shift-add multiplier and the restoring divider.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- dataD  in  decode_data_t  decoded instruction: valid, pc, raw_instr, dst, ra1, ra2, srca, srcb, memwd, ctl (alufunc, wordop, memread, memwrite, memsize, regwrite).
- flush  in  1  kill the in-flight op (branch redirect).
- stallmem  in  1  memory stage stalled; downstream register frozen.
- dataE  out  execute_data_t  valid, pc, raw_instr, dst, ra1, ra2, aluout, memwd, ctl.
- stallexe  out  1  hold the upstream stages and the D/E register.

Behaviour:
- Pass-through: dataE.pc, raw_instr, dst, ra1, ra2, memwd and ctl equal dataD, combinationally.
- dataE.valid = dataD.valid & ~flush & ~stallexe.
- Single-cycle ops:
  - ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shift amount is srcb[5:0]; srcb[4:0] when wordop.
  - Loads and stores use ADD, so aluout is the effective address.
  - Zero latency; stallexe=0.
- Word ops (wordop=1): compute on the low 32 bits; aluout = sign-extension of the 32-bit result.
- Multi-cycle ops: MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU, and the W forms of MUL/DIV/DIVU/REM/REMU.
  - W forms: operands are pre-extended from bit 31 (signed ops sign-extend, unsigned ops zero-extend). The result's low 32 bits are sign-extended.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - If dataD.valid, the op is multi-cycle and ~flush: capture the operands, stallexe=1.
    - Next state is BUSY with count=0, or DONE directly on a special case.
  - BUSY:
    - stallexe=1; one iteration per cycle; count increments.
    - When count reaches ITER-1, next state is DONE.
  - DONE:
    - stallexe=0; aluout = the latched result.
    - If ~stallmem, next state is IDLE; otherwise stay in DONE with the result held.
- Latency, normal op: stallexe is high for ITER+1 cycles (the arrival cycle plus ITER BUSY cycles). The result is presented in the next cycle.
- Latency, special case: stallexe is high for exactly 1 cycle.
- Special cases (bypass BUSY):
  - Divide by zero: quotient = all ones; remainder = the dividend (after W extension).
  - Signed overflow (most-negative / -1, at 64 or 32 bits per wordop): quotient = the dividend; remainder = 0.
- Signed handling: division uses magnitudes. Fix the signs at the end: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- MULH* forms use the full 128-bit product and return the upper 64 bits.
- flush:
  - Any state goes to IDLE next cycle; the result is discarded.
  - In the same cycle: stallexe=0 and dataE.valid=0.
  - flush has priority over a new op starting.
- stallmem during IDLE/BUSY does not pause iterations; the FSM waits in DONE.
- reset:
  - The FSM returns to IDLE from any state, mid-operation included.
  - count, result and operand registers are cleared.
  - stallexe=0 and dataE.valid=0 while reset is high.
- Back-to-back multi-cycle ops: DONE→IDLE. The next op is sampled in IDLE on the following cycle, so there is no skipped or duplicated op.
- Invalid dataD (valid=0): no FSM start; dataE.valid=0.

Test Plan:
- ADD srca=0x10, srcb=0xFFFF_FFFF_FFFF_FFF0 → aluout=0x0, stallexe=0; ADDW 0x7FFF_FFFF+1 → aluout=0xFFFF_FFFF_8000_0000.
- MUL 0x1234 × 0x10 → stallexe high 65 cycles, then aluout=0x12340 for one cycle; MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE.
- DIV -7/2 → quotient -3; REM -7/2 → -1; DIVU x/0 → all ones with stallexe high 1 cycle; DIV 0x8000_0000_0000_0000/-1 → 0x8000_0000_0000_0000.
- DIVW 0x1_0000_000A / 3 → 3 (upper bits ignored); REMUW 0xFFFF_FFFF/0x10 → 0xF.
- Assert flush at BUSY count=20 → IDLE next cycle, stallexe=0, dataE.valid=0. A following ADD completes normally.
- Hold stallmem for 3 cycles in DONE → aluout stable for those 3 cycles, FSM leaves DONE only after stallmem drops. Separately, reset mid-BUSY → IDLE, stallexe=0.

Source files
------------

// File: rtl/execute.sv
// Execute stage of the 64-bit in-order pipeline.
// Single-cycle ALU ops are combinational. MUL/DIV/REM ops run on an
// iterative shift-add / restoring unit, and stallexe holds the pipeline
// until their result is ready.
package execute_pkg;
  localparam int XW = 64;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULHSU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_func_t;

  typedef struct packed {
    alu_func_t   alufunc;
    logic        wordop;
    logic        memread;
    logic        memwrite;
    logic [1:0]  memsize;
    logic        regwrite;
  } ctl_t;

  typedef struct packed {
    logic          valid;
    logic [XW-1:0] pc;
    logic [31:0]   raw_instr;
    logic [4:0]    dst;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic [XW-1:0] srca;
    logic [XW-1:0] srcb;
    logic [XW-1:0] memwd;
    ctl_t          ctl;
  } decode_data_t;

  typedef struct packed {
    logic          valid;
    logic [XW-1:0] pc;
    logic [31:0]   raw_instr;
    logic [4:0]    dst;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic [XW-1:0] aluout;
    logic [XW-1:0] memwd;
    ctl_t          ctl;
  } execute_data_t;
endpackage

module execute
  import execute_pkg::*;
#(
  parameter int XLEN = XW,
  parameter int ITER = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  decode_data_t  dataD,
  input  logic          flush,
  input  logic          stallmem,
  output execute_data_t dataE,
  output logic          stallexe
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   opb_q, opb_d;      // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  alu_func_t         func_q, func_d;
  logic              wordop_q, wordop_d;
  logic              negq_q, negq_d;    // negate product / quotient at the end
  logic              negr_q, negr_d;    // negate remainder at the end
  logic              stall_c;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] x, input logic w);
    return w ? sext32(x[31:0]) : x;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  // One shift-add step: add multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   mcand);
    logic [XLEN:0] hi;
    hi = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    return {hi, acc[XLEN-1:1]};
  endfunction

  // One restoring-division step on {remainder, quotient}; the shifted
  // remainder needs XLEN+1 bits because it can exceed 2^XLEN-1.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   dvs);
    logic [XLEN:0]   hi;
    logic [XLEN+1:0] trial;
    logic            ge;
    hi    = acc[2*XLEN-1:XLEN-1];
    trial = {1'b0, hi} - {2'b00, dvs};
    ge    = ~trial[XLEN+1];
    return {(ge ? trial[XLEN-1:0] : hi[XLEN-1:0]), acc[XLEN-2:0], ge};
  endfunction

  // Apply sign fix-up, select the result half and word-extend.
  function automatic logic [XLEN-1:0] finalize(input alu_func_t f, input logic w,
                                               input logic nq, input logic nr,
                                               input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;
    prod = nq ? -acc : acc;
    quo  = nq ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = nr ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f)
      ALU_MUL:                        res = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHU, ALU_MULHSU: res = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:              res = quo;
      default:                        res = rem;
    endcase
    return wfix(res, w);
  endfunction

  alu_func_t        func_c;
  logic             wop_c, is_mul_c, is_div_c, is_rem_c, a_sgn_c, b_sgn_c, div0_c, ovf_c;
  logic [XLEN-1:0]  a_ext_c, b_ext_c, alu_c;
  logic [SH_W-1:0]  sh_c;
  logic [4:0]       shw_c;
  logic [31:0]      r32_c;
  logic signed [31:0] a32s_c;

  // Operand classification, W-form extension and special-case detection.
  always_comb begin
    func_c   = dataD.ctl.alufunc;
    wop_c    = dataD.ctl.wordop;
    is_mul_c = func_c inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULHSU};
    is_div_c = func_c inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    is_rem_c = func_c inside {ALU_REM, ALU_REMU};
    a_sgn_c  = func_c inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    b_sgn_c  = func_c inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    a_ext_c  = wop_c ? (a_sgn_c ? sext32(dataD.srca[31:0]) : {{(XLEN-32){1'b0}}, dataD.srca[31:0]})
                     : dataD.srca;
    b_ext_c  = wop_c ? (b_sgn_c ? sext32(dataD.srcb[31:0]) : {{(XLEN-32){1'b0}}, dataD.srcb[31:0]})
                     : dataD.srcb;
    div0_c   = (b_ext_c == '0);
    ovf_c    = (func_c inside {ALU_DIV, ALU_REM}) &&
               (wop_c ? (a_ext_c[31:0] == 32'h8000_0000 && b_ext_c[31:0] == '1)
                      : (a_ext_c == {1'b1, {(XLEN-1){1'b0}}} && b_ext_c == '1));
  end

  // Single-cycle ALU, 64-bit and word forms.
  always_comb begin
    sh_c   = dataD.srcb[SH_W-1:0];
    shw_c  = dataD.srcb[4:0];
    a32s_c = dataD.srca[31:0];
    case (func_c)
      ALU_SUB:  alu_c = dataD.srca - dataD.srcb;
      ALU_AND:  alu_c = dataD.srca & dataD.srcb;
      ALU_OR:   alu_c = dataD.srca | dataD.srcb;
      ALU_XOR:  alu_c = dataD.srca ^ dataD.srcb;
      ALU_SLL:  alu_c = dataD.srca << sh_c;
      ALU_SRL:  alu_c = dataD.srca >> sh_c;
      ALU_SRA:  alu_c = $signed(dataD.srca) >>> sh_c;
      ALU_SLT:  alu_c = {{(XLEN-1){1'b0}}, $signed(dataD.srca) < $signed(dataD.srcb)};
      ALU_SLTU: alu_c = {{(XLEN-1){1'b0}}, dataD.srca < dataD.srcb};
      default:  alu_c = dataD.srca + dataD.srcb;
    endcase
    case (func_c)
      ALU_ADD: r32_c = dataD.srca[31:0] + dataD.srcb[31:0];
      ALU_SUB: r32_c = dataD.srca[31:0] - dataD.srcb[31:0];
      ALU_SLL: r32_c = dataD.srca[31:0] << shw_c;
      ALU_SRL: r32_c = dataD.srca[31:0] >> shw_c;
      ALU_SRA: r32_c = a32s_c >>> shw_c;
      default: r32_c = alu_c[31:0];
    endcase
    if (wop_c) alu_c = sext32(r32_c);
  end

  // Iterative unit FSM: next state, operand capture, iteration and stall.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    func_d   = func_q;
    wordop_d = wordop_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dataD.valid && (is_mul_c || is_div_c) && !flush) begin
          stall_c  = 1'b1;
          func_d   = func_c;
          wordop_d = wop_c;
          count_d  = '0;
          negq_d   = (a_sgn_c & a_ext_c[XLEN-1]) ^ (b_sgn_c & b_ext_c[XLEN-1]);
          negr_d   = a_sgn_c & a_ext_c[XLEN-1];
          if (is_div_c && div0_c) begin
            result_d = wfix(is_rem_c ? a_ext_c : '1, wop_c);
            state_d  = DONE;
          end else if (ovf_c) begin
            result_d = wfix(is_rem_c ? '0 : a_ext_c, wop_c);
            state_d  = DONE;
          end else begin
            state_d = BUSY;
            if (is_mul_c) begin
              acc_d = {{XLEN{1'b0}}, mag(b_ext_c, b_sgn_c)};
              opb_d = mag(a_ext_c, a_sgn_c);
            end else begin
              acc_d = {{XLEN{1'b0}}, mag(a_ext_c, a_sgn_c)};
              opb_d = mag(b_ext_c, b_sgn_c);
            end
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        count_d = count_q + CNT_W'(1);
        acc_d   = (func_q inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_MULHSU})
                  ? mul_step(acc_q, opb_q) : div_step(acc_q, opb_q);
        if (count_q == CNT_W'(ITER-1)) begin
          state_d  = DONE;
          result_d = finalize(func_q, wordop_q, negq_q, negr_q, acc_d);
        end
      end
      DONE: begin
        if (!stallmem) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      stall_c = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      func_q   <= ALU_ADD;
      wordop_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      func_q   <= func_d;
      wordop_q <= wordop_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  // Output bundle: pass-through fields, result select and valid gating.
  always_comb begin
    stallexe        = stall_c & ~reset;
    dataE.valid     = dataD.valid & ~flush & ~stallexe & ~reset;
    dataE.pc        = dataD.pc;
    dataE.raw_instr = dataD.raw_instr;
    dataE.dst       = dataD.dst;
    dataE.ra1       = dataD.ra1;
    dataE.ra2       = dataD.ra2;
    dataE.memwd     = dataD.memwd;
    dataE.ctl       = dataD.ctl;
    dataE.aluout    = (state_q == DONE) ? result_q : alu_c;
  end
endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: the driver pushes expected
// results, a monitor pops and compares whenever dataE.valid is presented.
module tb_execute;
  import execute_pkg::*;

  logic          clk = 1'b0;
  logic          reset, flush, stallmem, stallexe;
  decode_data_t  dataD;
  execute_data_t dataE;

  execute #(.XLEN(64), .ITER(64)) dut (
    .clk(clk), .reset(reset), .dataD(dataD), .flush(flush),
    .stallmem(stallmem), .dataE(dataE), .stallexe(stallexe)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] q_val[$];
  logic [63:0] q_pc[$];
  int          q_stall[$];
  string       q_name[$];
  logic [63:0] pc_ctr = 64'h1000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: sampled mid-low-phase, after the driver has settled inputs.
  initial begin : monitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check("reset_stallexe", {63'b0, stallexe}, 64'd0);
        check("reset_valid", {63'b0, dataE.valid}, 64'd0);
        run = 0;
      end else if (flush) begin
        check("flush_stallexe", {63'b0, stallexe}, 64'd0);
        check("flush_valid", {63'b0, dataE.valid}, 64'd0);
        run = 0;
      end else begin
        if (!dataD.valid) check("invalid_in_valid", {63'b0, dataE.valid}, 64'd0);
        if (stallexe) run++;
        if (dataE.valid) begin
          if (q_val.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: aluout %h with nothing expected", dataE.aluout);
          end else begin
            check({q_name[0], "_aluout"}, dataE.aluout, q_val[0]);
            if (!stallmem) begin
              check({q_name[0], "_stallcycles"}, 64'(run), 64'(q_stall[0]));
              check({q_name[0], "_pc"}, dataE.pc, q_pc[0]);
              void'(q_val.pop_front());
              void'(q_pc.pop_front());
              void'(q_stall.pop_front());
              void'(q_name.pop_front());
              run = 0;
            end
          end
        end
      end
    end
  end

  task automatic drive(input alu_func_t f, input logic w, input logic [63:0] a, input logic [63:0] b);
    dataD               = '0;
    dataD.valid         = 1'b1;
    dataD.pc            = pc_ctr;
    dataD.raw_instr     = 32'h0000_0033;
    dataD.dst           = 5'd7;
    dataD.srca          = a;
    dataD.srcb          = b;
    dataD.memwd         = 64'hABCD;
    dataD.ctl.alufunc   = f;
    dataD.ctl.wordop    = w;
    dataD.ctl.regwrite  = 1'b1;
    pc_ctr              = pc_ctr + 64'd4;
  endtask

  // Called at a falling edge; returns at the falling edge after the op is consumed.
  task automatic issue(input string nm, input alu_func_t f, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                       input int stalls, input int hold);
    int cyc;
    drive(f, w, a, b);
    q_val.push_back(exp);
    q_pc.push_back(dataD.pc);
    q_stall.push_back(stalls);
    q_name.push_back(nm);
    #1;
    cyc = 0;
    while (stallexe && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (stallexe) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: stallexe still 1 after %0d cycles, expected 0", nm, cyc);
    end
    if (hold > 0) begin
      stallmem = 1'b1;
      repeat (hold) @(negedge clk);
      stallmem = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    dataD.valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    stallmem = 1'b0;
    drive(ALU_MUL, 1'b0, 64'd3, 64'd4);   // valid op under reset must not start or emit
    repeat (3) @(negedge clk);
    reset       = 1'b0;
    dataD.valid = 1'b0;
    @(negedge clk);

    issue("add",    ALU_ADD,  1'b0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 0, 0);
    issue("addw",   ALU_ADD,  1'b1, 64'h7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000, 0, 0);
    issue("sub",    ALU_SUB,  1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    issue("sra",    ALU_SRA,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 0, 0);
    issue("srlw",   ALU_SRL,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'h24, 64'h0000_0000_0800_0000, 0, 0);
    issue("sll",    ALU_SLL,  1'b0, 64'd1, 64'h43, 64'd8, 0, 0);
    issue("slt",    ALU_SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0, 0);
    issue("sltu",   ALU_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 0);
    issue("mul",    ALU_MUL,  1'b0, 64'h1234, 64'h10, 64'h12340, 65, 0);
    issue("mulhu",  ALU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    issue("mulh",   ALU_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    issue("mulhsu", ALU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    issue("mulw",   ALU_MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    issue("div",    ALU_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    issue("rem",    ALU_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    issue("divu0",  ALU_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    issue("rem0",   ALU_REM,  1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    issue("divovf", ALU_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, 0);
    issue("divw",   ALU_DIV,  1'b1, 64'h1_0000_000A, 64'd3, 64'd3, 65, 0);
    issue("remuw",  ALU_REMU, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'hF, 65, 0);
    issue("divwovf", ALU_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, 0);
    issue("divu_b2b", ALU_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
    issue("remu_b2b", ALU_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65, 0);
    issue("mul_hold", ALU_MUL, 1'b0, 64'd3, 64'd5, 64'd15, 65, 3);

    // Flush a MUL when the iteration count reaches 20, then an ADD follows.
    drive(ALU_MUL, 1'b0, 64'd9, 64'd9);
    repeat (21) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    issue("add_after_flush", ALU_ADD, 1'b0, 64'd1, 64'd2, 64'd3, 0, 0);

    // Reset in the middle of an iteration, then an XOR follows.
    drive(ALU_DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    dataD.valid = 1'b0;
    @(negedge clk);
    issue("xor_after_reset", ALU_XOR, 1'b0, 64'hF0, 64'hFF, 64'h0F, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(q_val.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
